// File: rtl/ma_pkg.sv
// Shared encodings and helpers for the memory access stage.
package ma_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} ma_state_t;

  // Byte-lane mask sized for up to 8 lanes; callers slice to their lane count.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return (off[0] == 1'b0);
      SZ_W:    return (off[1:0] == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// Right-justifies the addressed byte/half/word of a memory read and extends it.
module ma_load_align
  import ma_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sbit;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      SZ_B: begin
        keep = DATA_W'(8'hFF);
        sbit = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(16'hFFFF);
        sbit = shifted[15];
      end
      default: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
    endcase
    result = (shifted & keep) | ({DATA_W{sbit & ~uns}} & ~keep);
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipelined memory access stage: decodes ld/st requests, drives a latency-N
// synchronous memory and returns an aligned, extended result downstream.
module mem_access_stage
  import ma_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 7,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_isLd,
  input  logic                in_isSt,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [31:0]         in_addr,
  input  logic [DATA_W-1:0]   in_wd,
  input  logic [DATA_W-1:0]   in_aluR,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_err,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W/8;
  localparam int OFF_W = $clog2(NB);

  ma_state_t         state, state_nx;
  logic [2:0]        cnt;
  logic [OFF_W-1:0]  off, ld_off;
  logic [1:0]        ld_size;
  logic              ld_uns;
  logic              is_mem, illegal, accept, is_load;
  logic [7:0]        mask8;
  logic [DATA_W-1:0] ld_result;
  logic              unused_bits;

  assign off         = in_addr[OFF_W-1:0];
  assign is_mem      = in_isLd | in_isSt;
  // Size 11 is rejected by is_aligned, so it needs no separate term.
  assign illegal     = is_mem & ((in_isLd & in_isSt) | ~is_aligned(in_size, 3'(off)));
  assign accept      = in_valid & in_ready;
  assign is_load     = in_isLd & ~illegal;
  assign mask8       = lane_mask(in_size, 3'(off));
  assign unused_bits = ^{in_addr[31:OFF_W+ADDR_W], mask8};
  assign out_valid   = (state == HOLD);

  always_comb begin
    case (state)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept && is_mem && !illegal) begin
      mem_en   = 1'b1;
      mem_addr = in_addr[OFF_W+ADDR_W-1:OFF_W];
      if (in_isSt) begin
        mem_we = mask8[NB-1:0];
        case (in_size)
          SZ_B:    mem_wdata = {NB{in_wd[7:0]}};
          SZ_H:    mem_wdata = {(NB/2){in_wd[15:0]}};
          default: mem_wdata = {(NB/4){in_wd[31:0]}};
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = is_load ? WAIT : HOLD;
      WAIT: if (cnt == 3'd1) state_nx = HOLD;
      HOLD: if (out_ready) state_nx = accept ? (is_load ? WAIT : HOLD) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  ma_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata  (mem_rdata),
    .off    (ld_off),
    .size   (ld_size),
    .uns    (ld_uns),
    .result (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
      ld_off   <= '0;
      ld_size  <= SZ_B;
      ld_uns   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (is_load) begin
          cnt     <= 3'(MEM_LATENCY);
          ld_off  <= off;
          ld_size <= in_size;
          ld_uns  <= in_unsigned;
        end else begin
          out_err  <= illegal;
          out_data <= illegal ? '0 : (in_isSt ? in_wd : in_aluR);
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          out_data <= ld_result;
          out_err  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 2-cycle-latency byte-write memory.
module tb_mem_access_stage;

  localparam int DW  = 32;
  localparam int AW  = 7;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_ready;
  logic          in_isLd = 1'b0, in_isSt = 1'b0;
  logic [1:0]    in_size = 2'b00;
  logic          in_unsigned = 1'b0;
  logic [31:0]   in_addr = '0;
  logic [DW-1:0] in_wd = '0, in_aluR = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [31:0]   mem   [128];
  logic [31:0]   rpipe [LAT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_isLd(in_isLd), .in_isSt(in_isSt), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_addr(in_addr), .in_wd(in_wd), .in_aluR(in_aluR),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
    rpipe[0] <= mem[mem_addr];
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wd, alu;
    logic        en;
    logic [3:0]  we;
    logic [6:0]  maddr;
    logic [31:0] wdata, data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic ld, st, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, wd, alu, input logic en,
                              input logic [3:0] we, input logic [6:0] maddr,
                              input logic [31:0] wdata, data, input logic err, input int lat);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd; v.alu = alu;
    v.en = en; v.we = we; v.maddr = maddr; v.wdata = wdata; v.data = data; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   lat;
    v = vecs[i];
    in_valid = 1'b1; in_isLd = v.ld; in_isSt = v.st; in_size = v.sz; in_unsigned = v.uns;
    in_addr = v.addr; in_wd = v.wd; in_aluR = v.alu; out_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
    chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(v.en));
    chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(v.we));
    if (v.en) chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(v.maddr));
    if (v.en && v.st) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
    @(posedge clk); #1;
    in_valid = 1'b0; in_isLd = 1'b0; in_isSt = 1'b0;
    lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (lat == 1) chk($sformatf("v%0d in_ready_wait", i), 32'(in_ready), 32'd0);
    end
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d out_data", i), out_data, v.data);
    chk($sformatf("v%0d out_err", i), 32'(out_err), 32'(v.err));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] pv [4];
    int          idx_in, idx_out, lat;

    vecs[0]  = mk(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 1, 4'b1111, 7'd4, 32'hDEADBEEF, 32'hDEADBEEF, 0, 1);
    vecs[1]  = mk(1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 4'b0000, 7'd4, 0, 32'hDEADBEEF, 0, 3);
    vecs[2]  = mk(1, 0, 2'b00, 0, 32'h13, 0, 0, 1, 4'b0000, 7'd4, 0, 32'hFFFFFFDE, 0, 3);
    vecs[3]  = mk(1, 0, 2'b00, 1, 32'h13, 0, 0, 1, 4'b0000, 7'd4, 0, 32'h000000DE, 0, 3);
    vecs[4]  = mk(1, 0, 2'b01, 0, 32'h12, 0, 0, 1, 4'b0000, 7'd4, 0, 32'hFFFFDEAD, 0, 3);
    vecs[5]  = mk(0, 1, 2'b01, 0, 32'h22, 32'hABCD1234, 0, 1, 4'b1100, 7'd8, 32'h12341234, 32'hABCD1234, 0, 1);
    vecs[6]  = mk(1, 0, 2'b01, 1, 32'h22, 0, 0, 1, 4'b0000, 7'd8, 0, 32'h00001234, 0, 3);
    vecs[7]  = mk(0, 1, 2'b00, 0, 32'h25, 32'h00000080, 0, 1, 4'b0010, 7'd9, 32'h80808080, 32'h00000080, 0, 1);
    vecs[8]  = mk(1, 0, 2'b00, 0, 32'h25, 0, 0, 1, 4'b0000, 7'd9, 0, 32'hFFFFFF80, 0, 3);
    vecs[9]  = mk(1, 0, 2'b10, 0, 32'h11, 0, 32'h55, 0, 4'b0000, 7'd0, 0, 32'h0, 1, 1);
    vecs[10] = mk(1, 1, 2'b10, 0, 32'h10, 32'h77, 32'h55, 0, 4'b0000, 7'd0, 0, 32'h0, 1, 1);
    vecs[11] = mk(1, 0, 2'b11, 0, 32'h10, 0, 32'h55, 0, 4'b0000, 7'd0, 0, 32'h0, 1, 1);
    vecs[12] = mk(1, 0, 2'b01, 0, 32'h13, 0, 32'h55, 0, 4'b0000, 7'd0, 0, 32'h0, 1, 1);
    vecs[13] = mk(0, 0, 2'b11, 0, 32'h13, 0, 32'h12345678, 0, 4'b0000, 7'd0, 0, 32'h12345678, 0, 1);
    vecs[14] = mk(1, 0, 2'b00, 1, 32'h10, 0, 0, 1, 4'b0000, 7'd4, 0, 32'h000000EF, 0, 3);
    vecs[15] = mk(1, 0, 2'b01, 0, 32'h10, 0, 0, 1, 4'b0000, 7'd4, 0, 32'hFFFFBEEF, 0, 3);

    repeat (2) @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Back-to-back pass-throughs with a two-cycle downstream stall.
    pv[0] = 32'hA0A0_0001; pv[1] = 32'hB0B0_0002; pv[2] = 32'hC0C0_0003; pv[3] = 32'hD0D0_0004;
    idx_in = 0; idx_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid  = (idx_in < 4);
      in_isLd   = 1'b0; in_isSt = 1'b0;
      in_aluR   = (idx_in < 4) ? pv[idx_in] : 32'h0;
      out_ready = (cyc != 2) && (cyc != 3);
      @(negedge clk);
      if (out_valid) begin
        if (idx_out < 4) chk($sformatf("stream data%0d", idx_out), out_data, pv[idx_out]);
        else chk("stream extra output", 32'(out_valid), 32'd0);
        if (!out_ready) begin
          chk("stall in_ready", 32'(in_ready), 32'd0);
          chk("stall mem_en", 32'(mem_en), 32'd0);
        end else idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream accepted", 32'(idx_in), 32'd4);
    chk("stream delivered", 32'(idx_out), 32'd4);

    // Reset while a load is waiting on memory.
    in_valid = 1'b1; in_isLd = 1'b1; in_size = 2'b10; in_addr = 32'h10;
    @(posedge clk); #1;
    in_valid = 1'b0; in_isLd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_wait out_valid c%0d", c), 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_aluR = 32'h0BAD_F00D;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk("post_rst latency", 32'(lat), 32'd1);
    chk("post_rst out_data", out_data, 32'h0BAD_F00D);
    chk("post_rst out_err", 32'(out_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised, pipelined successor to the single-cycle memory access unit of the SimpleRISC core. Sits between the EX/MA and MA/RW pipeline registers. Accepts one load, store or pass-through op per valid/ready handshake, drives a synchronous data memory of configurable read latency with byte-lane write enables, and returns an aligned, sign- or zero-extended result to write-back. Supports byte, half and word accesses and flags misaligned or illegal requests.

## Interface
- `DATA_W`, 32: datapath width; legal values are 32 and 64. `NB = DATA_W/8` lanes; `OFF_W = log2(NB)`.
- `ADDR_W`, 7: word-address width of the data memory.
- `MEM_LATENCY`, 1: clock edges from read issue to valid `mem_rdata`; range 1..4.
- `clk` in 1: single clock; memory is also clocked on `clk`.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream op valid.
- `in_ready` out 1: stage can accept this cycle.
- `in_isLd`, `in_isSt` in 1 each: op is load / store.
- `in_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `in_unsigned` in 1: zero-extend load; otherwise sign-extend.
- `in_addr` in 32: byte address (RWA).
- `in_wd` in DATA_W: store data, right-justified.
- `in_aluR` in DATA_W: pass-through result for non-memory ops.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_data` out DATA_W: load result or `in_aluR`.
- `out_err` out 1: op was misaligned or illegal; no memory access was made.
- `mem_en` out 1, `mem_we` out NB, `mem_addr` out ADDR_W, `mem_wdata` out DATA_W: memory request, combinational in the accept cycle.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- Accept occurs when `in_valid & in_ready`. The `mem_*` outputs are nonzero only in an accept cycle of a legal load or store; otherwise `mem_en=0` and `mem_we=0`.
- `mem_addr = in_addr[OFF_W+ADDR_W-1:OFF_W]`. Byte offset `off = in_addr[OFF_W-1:0]`.
- Illegal conditions: `in_isLd & in_isSt`, `in_size==11`, or `off` not a multiple of the access size. An illegal op makes no memory access and completes like a pass-through with `out_data=0` and `out_err=1`.
- Store: `mem_we` sets the `size` lanes starting at lane `off`. `mem_wdata` is the low byte, half or word of `in_wd` replicated across all lanes. `out_data = in_wd`.
- Load: `mem_en=1` and `mem_we=0`. After `MEM_LATENCY` edges, `mem_rdata` is shifted right by `off*8` and extended from 8, 16 or 32 bits to DATA_W per `in_unsigned`. The result is registered into `out_data`.
- Pass-through (neither isLd nor isSt): `out_data = in_aluR`, `out_err=0`.
- FSM states:
  - IDLE: `in_ready=1`.
    - On accepting a load, go to WAIT and load counter = `MEM_LATENCY`.
    - On accepting any other op, go to HOLD.
  - WAIT: `in_ready=0`. Decrement the counter each cycle. When the counter reaches 1, capture the extracted data and go to HOLD.
  - HOLD: `out_valid=1`; `out_data` and `out_err` are stable.
    - `in_ready = out_ready` (back-to-back acceptance).
    - On `out_ready`: a new accept follows the IDLE rules; no accept returns to IDLE.
- Load offset, size and unsigned flag are captured at accept and used at capture time.

## Timing
- Reset (async assert): state IDLE, `out_valid=0`, `out_data=0`, `out_err=0`, counter 0.
- Reset mid-WAIT or mid-HOLD discards the op and produces no output. A store already issued stays written.
- Latency from accept edge to `out_valid`:
  - 1 cycle for store, pass-through and illegal ops.
  - `MEM_LATENCY+1` cycles for loads.
- Throughput: 1 op/cycle for non-loads under continuous `out_ready`. A load blocks acceptance for `MEM_LATENCY` cycles.
- Downstream stall (`out_ready=0` in HOLD): outputs hold, `in_ready=0`, `mem_*` idle.
- Deassertion of `rst_n` is synchronised externally. The first accept can occur at the first edge after release.

## Structure
- Package `ma_pkg` holds:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - the state enum (IDLE, WAIT, HOLD);
  - functions `lane_mask(size, off)` and `is_aligned(size, off)`.
- Sub-module `ma_load_align`: combinational shift plus sign/zero extension of `mem_rdata`, parametrised on `DATA_W`.
- The top level contains the FSM, latency counter, request decode and output registers.

## Test plan
- Store word 0xDEADBEEF to addr 0x10, then load word from 0x10 with `MEM_LATENCY=2` -> `mem_we=4'b1111`, `mem_addr=4`; load `out_valid` 3 cycles after accept; `out_data=0xDEADBEEF`.
- Load byte signed from 0x13 holding 0xDE -> `out_data=0xFFFFFFDE`; unsigned -> `0x000000DE`. Load half signed from 0x12 -> `0xFFFFDEAD`.
- Store half 0x1234 to 0x22 -> `mem_we=4'b1100`, `mem_wdata=0x12341234`.
- Load word from 0x11 -> no `mem_en`; `out_err=1`, `out_data=0` one cycle later. The same result occurs with `isLd=isSt=1`.
- Four back-to-back pass-throughs with `out_ready` low for 2 cycles mid-stream -> all four emerge in order, none lost or duplicated, `in_ready` low during the stall.
- Assert `rst_n=0` during WAIT of a load -> `out_valid` stays 0. After release, a pass-through completes in 1 cycle.
